// File: rtl/ysyx_22040750_ifu_pkg.sv
// Shared types and constants for the IFU PC/fetch sequencer.
//   ifu_state_e  : fetch sequencer state (IDLE/REQ/WAIT/HOLD)
//   RESET_PC_DEF : default first fetch address after reset
//   NOP_INST     : addi x0,x0,0, substituted for misaligned fetches
//   snpc_of()    : sequential next PC, wraps modulo 2^32
package ysyx_22040750_ifu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,   // waiting for a dnpc
    S_REQ  = 2'd1,   // imem request outstanding, waiting for gnt
    S_WAIT = 2'd2,   // granted, waiting for rvalid
    S_HOLD = 2'd3    // instruction presented to IF/ID
  } ifu_state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;

  function automatic logic [31:0] snpc_of(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/ysyx_22040750_if_id_reg.sv
// IF/ID output register: holds pc/snpc/inst and the valid flag.
//   I_clk, I_rst : clock, synchronous active-high reset
//   load         : capture pc_d/inst_d and raise valid
//   clear        : drop valid (data kept, it is don't-care when invalid)
//   pc_d, inst_d : values to capture
//   valid, pc, snpc, inst : registered outputs toward decode
module ysyx_22040750_if_id_reg
  import ysyx_22040750_ifu_pkg::*;
(
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] pc_d,
  input  logic [31:0] inst_d,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] snpc,
  output logic [31:0] inst
);

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      valid <= 1'b0;
      pc    <= 32'd0;
      snpc  <= 32'd0;
      inst  <= 32'd0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= pc_d;
      snpc  <= snpc_of(pc_d);
      inst  <= inst_d;
    end
  end

endmodule

// File: rtl/ysyx_22040750_ifu_pc.sv
// PC register and fetch sequencer. Accepts dnpc, issues one imem request at
// a time, captures the returned word and presents pc/snpc/inst to IF/ID.
//   I_clk, I_rst        : clock, synchronous active-high reset
//   I_dnpc*/O_dnpc_ready: next-PC handshake (IFU is the consumer)
//   I_flush             : kill in-flight fetch or held instruction
//   O_imem_* / I_imem_* : instruction memory req/gnt, rvalid/rdata
//   O_IF_ID_* / I_IF_ID_ready : IF/ID valid/ready handshake
// Optional feature: YSYX_22040750_IFU_MISALIGN_EN adds O_IF_ID_misalign and
// turns misaligned fetches into a flagged nop without touching imem.
module ysyx_22040750_ifu_pc
  import ysyx_22040750_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic [31:0] I_dnpc,
  input  logic        I_dnpc_valid,
  output logic        O_dnpc_ready,
  input  logic        I_flush,
  output logic        O_imem_req,
  output logic [31:0] O_imem_addr,
  input  logic        I_imem_gnt,
  input  logic        I_imem_rvalid,
  input  logic [31:0] I_imem_rdata,
  output logic        O_IF_ID_valid,
  input  logic        I_IF_ID_ready,
  output logic [31:0] O_IF_ID_pc,
  output logic [31:0] O_IF_ID_snpc,
  output logic [31:0] O_IF_ID_inst
`ifdef YSYX_22040750_IFU_MISALIGN_EN
  ,
  output logic        O_IF_ID_misalign
`endif
);

  ifu_state_e  state;
  logic [31:0] pc;
  logic        drop;      // a granted response must be discarded
  logic        pc_misal;
  logic        dnpc_fire;
  logic        reg_load;
  logic        reg_clear;
  logic [31:0] reg_inst;
  logic        reg_valid;

`ifdef YSYX_22040750_IFU_MISALIGN_EN
  assign pc_misal = (pc[1:0] != 2'b00);
`else
  assign pc_misal = 1'b0;
`endif

  // Flush masks dnpc acceptance so a killed HOLD cannot chain a new fetch.
  assign O_dnpc_ready = ~I_rst & ~I_flush &
                        ((state == S_IDLE) | ((state == S_HOLD) & I_IF_ID_ready));
  assign dnpc_fire    = O_dnpc_ready & I_dnpc_valid;
  assign O_imem_req   = ~I_rst & (state == S_REQ) & ~pc_misal;
  assign O_imem_addr  = pc;

  // Load from a clean response, or the nop path for a misaligned pc.
  assign reg_load  = ((state == S_WAIT) & I_imem_rvalid & ~I_flush & ~drop) |
                     ((state == S_REQ) & pc_misal & ~I_flush);
  assign reg_clear = (state == S_HOLD) & (I_flush | I_IF_ID_ready);
  assign reg_inst  = (state == S_REQ) ? NOP_INST : I_imem_rdata;

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state <= S_REQ;
      pc    <= RESET_PC;
      drop  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (dnpc_fire) begin
            pc    <= I_dnpc;
            state <= S_REQ;
          end
        end
        S_REQ: begin
          if (I_flush) begin
            // A granted request still owes a response; remember to drop it.
            if (I_imem_gnt & ~pc_misal) begin
              drop  <= 1'b1;
              state <= S_WAIT;
            end else begin
              state <= S_IDLE;
            end
          end else if (pc_misal) begin
            state <= S_HOLD;
          end else if (I_imem_gnt) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (I_imem_rvalid) begin
            drop  <= 1'b0;
            state <= (I_flush | drop) ? S_IDLE : S_HOLD;
          end else if (I_flush) begin
            drop <= 1'b1;
          end
        end
        S_HOLD: begin
          if (I_flush) begin
            state <= S_IDLE;
          end else if (I_IF_ID_ready) begin
            if (dnpc_fire) begin
              pc    <= I_dnpc;
              state <= S_REQ;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  ysyx_22040750_if_id_reg u_if_id_reg (
    .I_clk  (I_clk),
    .I_rst  (I_rst),
    .load   (reg_load),
    .clear  (reg_clear),
    .pc_d   (pc),
    .inst_d (reg_inst),
    .valid  (reg_valid),
    .pc     (O_IF_ID_pc),
    .snpc   (O_IF_ID_snpc),
    .inst   (O_IF_ID_inst)
  );

  assign O_IF_ID_valid = ~I_rst & reg_valid;

`ifdef YSYX_22040750_IFU_MISALIGN_EN
  logic misal_q;

  // Rewritten on every load, so a normal fetch clears it.
  always_ff @(posedge I_clk) begin
    if (I_rst)         misal_q <= 1'b0;
    else if (reg_load) misal_q <= pc_misal;
  end

  assign O_IF_ID_misalign = ~I_rst & misal_q;
`endif

endmodule

// File: tb/tb_ysyx_22040750_ifu_pc.sv
// Directed bench for ysyx_22040750_ifu_pc: a transaction-level model tracks
// what the IFU owes (a pending fetch, a granted fetch, a held instruction)
// and a compare process checks outputs every cycle; literal checks in the
// stimulus pin the model to hand-computed values.
module tb_ysyx_22040750_ifu_pc;

`ifdef YSYX_22040750_IFU_MISALIGN_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk, rst;
  logic [31:0] dnpc;
  logic        dv, flush, gnt, rvalid, ifr;
  logic [31:0] rdata;
  logic        dnpc_ready, req, valid, misalign;
  logic [31:0] addr, opc, osnpc, oinst;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;

  ysyx_22040750_ifu_pc dut (
    .I_clk           (clk),
    .I_rst           (rst),
    .I_dnpc          (dnpc),
    .I_dnpc_valid    (dv),
    .O_dnpc_ready    (dnpc_ready),
    .I_flush         (flush),
    .O_imem_req      (req),
    .O_imem_addr     (addr),
    .I_imem_gnt      (gnt),
    .I_imem_rvalid   (rvalid),
    .I_imem_rdata    (rdata),
    .O_IF_ID_valid   (valid),
    .I_IF_ID_ready   (ifr),
    .O_IF_ID_pc      (opc),
    .O_IF_ID_snpc    (osnpc),
    .O_IF_ID_inst    (oinst)
`ifdef YSYX_22040750_IFU_MISALIGN_EN
    ,
    .O_IF_ID_misalign(misalign)
`endif
  );

`ifndef YSYX_22040750_IFU_MISALIGN_EN
  assign misalign = 1'b0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- model: obligations, not states ----------------
  bit          m_init = 0;
  bit          m_fetch, m_granted, m_drop, m_have, m_hmis;
  logic [31:0] m_pc, m_hpc, m_hinst;
  bit          e_idle, e_mis, e_req, e_rdy, e_val;

  always_comb begin
    e_idle = !m_fetch && !m_granted && !m_have;
    e_mis  = MIS_EN && (m_pc[1:0] != 2'b00);
    e_req  = !rst && m_fetch && !e_mis;
    e_rdy  = !rst && !flush && (e_idle || (m_have && ifr));
    e_val  = !rst && m_have;
  end

  always @(posedge clk) begin
    bit f, g, d, h, hm, fire;
    logic [31:0] p, hp, hi;
    f = m_fetch; g = m_granted; d = m_drop; h = m_have; hm = m_hmis;
    p = m_pc; hp = m_hpc; hi = m_hinst;
    fire = e_rdy && dv;
    if (rst) begin
      f = 1; g = 0; d = 0; h = 0; p = 32'h8000_0000;
    end else if (f) begin
      if (e_mis) begin
        f = 0;
        if (!flush) begin h = 1; hp = p; hi = 32'h13; hm = 1; end
      end else if (gnt) begin
        f = 0; g = 1; d = flush;
      end else if (flush) begin
        f = 0;
      end
    end else if (g) begin
      if (rvalid) begin
        g = 0;
        if (!(flush || d)) begin h = 1; hp = p; hi = rdata; hm = 0; end
        d = 0;
      end else if (flush) d = 1;
    end else if (h) begin
      if (flush) h = 0;
      else if (ifr) begin
        h = 0;
        if (fire) begin p = dnpc; f = 1; end
      end
    end else if (fire) begin
      p = dnpc; f = 1;
    end
    m_fetch <= f; m_granted <= g; m_drop <= d; m_have <= h; m_hmis <= hm;
    m_pc <= p; m_hpc <= hp; m_hinst <= hi;
    if (rst) m_init <= 1;
    if (!rst && valid && ifr && !flush) hs_cnt <= hs_cnt + 1;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    #1;
    if (m_init) begin
      chk("req", 32'(req), 32'(e_req));
      chk("dnpc_ready", 32'(dnpc_ready), 32'(e_rdy));
      chk("valid", 32'(valid), 32'(e_val));
      if (e_req) chk("addr", addr, m_pc);
      if (e_val) begin
        chk("pc", opc, m_hpc);
        chk("snpc", osnpc, m_hpc + 32'd4);
        chk("inst", oinst, m_hinst);
        if (MIS_EN) chk("misalign", 32'(misalign), 32'(m_hmis));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic nxt();
    @(negedge clk);
    gnt = 0; rvalid = 0; flush = 0; dv = 0; ifr = 0;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    rst = 1; dnpc = 0; dv = 0; flush = 0; gnt = 0; rvalid = 0; rdata = 0; ifr = 0;
    nxt(); nxt(); settle();
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_dnpc_ready", 32'(dnpc_ready), 32'd0);

    // reset release: req at RESET_PC, gnt now, rvalid next
    nxt(); rst = 0; gnt = 1; settle();
    chk("first_req", 32'(req), 32'd1);
    chk("first_addr", addr, 32'h8000_0000);
    nxt(); rvalid = 1; rdata = 32'h0000_0093;
    nxt(); settle();
    chk("first_valid", 32'(valid), 32'd1);
    chk("first_pc", opc, 32'h8000_0000);
    chk("first_snpc", osnpc, 32'h8000_0004);
    chk("first_inst", oinst, 32'h0000_0093);
    // backpressure
    nxt(); settle();
    chk("bp_dnpc_ready", 32'(dnpc_ready), 32'd0);
    chk("bp_inst", oinst, 32'h0000_0093);
    nxt(); settle();
    chk("bp_pc", opc, 32'h8000_0000);
    nxt(); ifr = 1; dv = 1; dnpc = 32'h8000_0010; settle();
    chk("chain_dnpc_ready", 32'(dnpc_ready), 32'd1);

    // delayed gnt with a stray rvalid
    nxt(); settle();
    chk("chain_req", 32'(req), 32'd1);
    chk("chain_addr", addr, 32'h8000_0010);
    nxt(); rvalid = 1; rdata = 32'hdead_beef;
    nxt();
    nxt(); settle();
    chk("held_addr", addr, 32'h8000_0010);
    nxt(); gnt = 1;
    nxt(); rvalid = 1; rdata = 32'h0010_0113;
    nxt(); ifr = 1; settle();
    chk("second_inst", oinst, 32'h0010_0113);
    chk("second_pc", opc, 32'h8000_0010);

    // flush in WAIT, response 2 cycles later is discarded
    nxt(); dv = 1; dnpc = 32'h8000_0020; settle();
    chk("idle_dnpc_ready", 32'(dnpc_ready), 32'd1);
    nxt(); gnt = 1;
    nxt(); flush = 1;
    nxt();
    nxt(); rvalid = 1; rdata = 32'h1111_1111;
    nxt(); dv = 1; dnpc = 32'h8000_0100; settle();
    chk("wflush_valid", 32'(valid), 32'd0);
    chk("wflush_idle", 32'(dnpc_ready), 32'd1);
    nxt(); gnt = 1; settle();
    chk("refetch_addr", addr, 32'h8000_0100);
    nxt(); rvalid = 1; rdata = 32'h00a0_0093;
    nxt(); ifr = 1; dv = 1; dnpc = 32'h8000_0200; settle();
    chk("refetch_pc", opc, 32'h8000_0100);
    chk("refetch_inst", oinst, 32'h00a0_0093);

    // flush with gnt in REQ: response dropped
    nxt(); gnt = 1; flush = 1; settle();
    chk("rflush_req", 32'(req), 32'd1);
    nxt(); settle();
    chk("rflush_wait_valid", 32'(valid), 32'd0);
    nxt(); rvalid = 1; rdata = 32'h2222_2222;
    // flush in IDLE blocks dnpc acceptance
    nxt(); flush = 1; dv = 1; dnpc = 32'h8000_0400; settle();
    chk("iflush_dnpc_ready", 32'(dnpc_ready), 32'd0);
    chk("dropped_valid", 32'(valid), 32'd0);

    // snpc wraparound, then flush in HOLD concurrent with ready
    nxt(); dv = 1; dnpc = 32'hffff_fffc;
    nxt(); gnt = 1; settle();
    chk("wrap_addr", addr, 32'hffff_fffc);
    nxt(); rvalid = 1; rdata = 32'h1357_9bdf;
    nxt(); flush = 1; ifr = 1; dv = 1; dnpc = 32'h8000_0500; settle();
    chk("wrap_snpc", osnpc, 32'h0000_0000);
    chk("wrap_pc", opc, 32'hffff_fffc);
    chk("hflush_dnpc_ready", 32'(dnpc_ready), 32'd0);
    nxt(); dv = 1; dnpc = 32'h8000_0300; settle();
    chk("hflush_valid", 32'(valid), 32'd0);

    // flush in REQ without gnt
    nxt(); flush = 1; settle();
    chk("rnflush_req", 32'(req), 32'd1);
    nxt(); dv = 1; dnpc = 32'h8000_0600; settle();
    chk("rnflush_idle_req", 32'(req), 32'd0);
    // flush in WAIT together with rvalid
    nxt(); gnt = 1;
    nxt(); flush = 1; rvalid = 1; rdata = 32'h3333_3333;
    nxt(); settle();
    chk("wrflush_valid", 32'(valid), 32'd0);
    chk("wrflush_idle", 32'(dnpc_ready), 32'd1);

`ifdef YSYX_22040750_IFU_MISALIGN_EN
    nxt(); dv = 1; dnpc = 32'h8000_0002;
    nxt(); settle();
    chk("mis_no_req", 32'(req), 32'd0);
    nxt(); ifr = 1; dv = 1; dnpc = 32'h8000_0700; settle();
    chk("mis_valid", 32'(valid), 32'd1);
    chk("mis_inst", oinst, 32'h0000_0013);
    chk("mis_flag", 32'(misalign), 32'd1);
    nxt(); gnt = 1;
    nxt(); rvalid = 1; rdata = 32'h0000_0093;
    nxt(); ifr = 1; settle();
    chk("mis_flag_clear", 32'(misalign), 32'd0);
`endif

    nxt(); nxt();
    chk("handshakes", 32'(hs_cnt), MIS_EN ? 32'd5 : 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
